// File: rtl/calc_fsm.sv
// Four-function unsigned calculator FSM (IDLE -> CALC -> DONE) with range/error flagging.
// Optional macro CALC_DIV_EN builds the 14-step restoring divider for opcode 11.
module calc_fsm #(
    parameter int MAX_VAL = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic [13:0] op_a,
    input  logic [13:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [13:0] Result,
    output logic        flag
);

    localparam int DATA_W = 14;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [PROD_W-1:0] MAX_W = PROD_W'(MAX_VAL);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_rng_err;
    logic              r_busy;
    logic              r_done;
    logic              r_flag;
    logic [DATA_W-1:0] r_result;

    logic              w_ld;
    logic              w_fin;
    logic              w_fin_err;
    logic [DATA_W-1:0] w_fin_res;
    logic [DATA_W:0]   w_sum;
    logic [PROD_W-1:0] w_prod;

    function automatic logic over_max(input logic [PROD_W-1:0] v);
        return v > MAX_W;
    endfunction

    // Full-width sum and product so the range check sees the true value
    always_comb begin
        w_sum  = (DATA_W+1)'(r_a) + (DATA_W+1)'(r_b);
        w_prod = PROD_W'(r_a) * PROD_W'(r_b);
    end

`ifdef CALC_DIV_EN
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic              w_div_step;
    logic [3:0]        w_idx;
    logic [DATA_W:0]   w_shift;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_nxt;

    // One restoring step: bring down the next dividend bit, subtract if it fits
    always_comb begin
        w_idx     = 4'(DATA_W - 1) - r_cnt;
        w_shift   = {r_rem, r_a[w_idx]};
        w_qbit    = (w_shift >= {1'b0, r_b});
        w_rem_nxt = w_qbit ? DATA_W'(w_shift - {1'b0, r_b}) : w_shift[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else if (w_ld) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else if (w_div_step) begin
            r_cnt <= r_cnt + 4'd1;
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[DATA_W-2:0], w_qbit};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ld      = 1'b0;
        w_fin     = 1'b0;
        w_fin_err = 1'b0;
        w_fin_res = '0;
`ifdef CALC_DIV_EN
        w_div_step = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_ld   = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                case (r_op)
                    OP_ADD: begin
                        w_fin     = 1'b1;
                        w_fin_err = r_rng_err || over_max(PROD_W'(w_sum));
                        w_fin_res = w_sum[DATA_W-1:0];
                    end
                    OP_SUB: begin
                        w_fin     = 1'b1;
                        w_fin_err = r_rng_err || (r_a < r_b);
                        w_fin_res = r_a - r_b;
                    end
                    OP_MUL: begin
                        w_fin     = 1'b1;
                        w_fin_err = r_rng_err || over_max(w_prod);
                        w_fin_res = w_prod[DATA_W-1:0];
                    end
                    default: begin
`ifdef CALC_DIV_EN
                        // Bad operands or divide-by-zero abort in the first CALC cycle
                        if ((r_cnt == 4'd0) && (r_rng_err || (r_b == '0))) begin
                            w_fin     = 1'b1;
                            w_fin_err = 1'b1;
                        end else begin
                            w_div_step = 1'b1;
                            if (r_cnt == 4'(DATA_W - 1)) begin
                                w_fin     = 1'b1;
                                w_fin_res = {r_quo[DATA_W-2:0], w_qbit};
                                w_fin_err = over_max(PROD_W'(w_fin_res));
                            end
                        end
`else
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
`endif
                    end
                endcase
                if (w_fin) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rng_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_flag    <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_ld) begin
                r_op      <= opcode;
                r_a       <= op_a;
                r_b       <= op_b;
                r_rng_err <= over_max(PROD_W'(op_a)) || over_max(PROD_W'(op_b));
                r_busy    <= 1'b1;
            end
            if (w_fin) begin
                r_busy   <= 1'b0;
                r_result <= w_fin_err ? '0 : w_fin_res;
                r_flag   <= w_fin_err;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign Result = r_result;
    assign flag   = r_flag;

endmodule

// File: tb/tb_calc_fsm.sv
// Self-checking bench for calc_fsm: directed cases plus random operations against an arithmetic model.
// Honours CALC_DIV_EN the same way as the design build.
module tb_calc_fsm;

    localparam int MAX = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  opcode;
    logic [13:0] op_a;
    logic [13:0] op_b;
    logic        busy;
    logic        done;
    logic [13:0] Result;
    logic        flag;

    int n_chk  = 0;
    int n_fail = 0;

    calc_fsm #(.MAX_VAL(MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .flag   (flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        opcode = 2'($urandom);
        op_a   = 14'($urandom);
        op_b   = 14'($urandom);
    endtask

    // Expected outcome from plain integer arithmetic; lat = -1 means latency unchecked.
    // lat counts edges with the edge that sampled start as edge 1.
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int res, output bit flg, output int lat);
        int r;
        bit err;
        err = (a > MAX) || (b > MAX);
        lat = 2;
        r   = 0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            default: begin
`ifdef CALC_DIV_EN
                if (b == 0) begin
                    err = 1'b1;
                end else begin
                    r   = a / b;
                    lat = err ? -1 : 15;
                end
`else
                err = 1'b1;
`endif
            end
        endcase
        if (r < 0 || r > MAX) err = 1'b1;
        res = err ? 0 : r;
        flg = err;
    endfunction

    task automatic run_op(input int op, input int a, input int b, input bit mid_start);
        int cnt;
        int e_res;
        bit e_flg;
        int e_lat;
        ref_op(op, a, b, e_res, e_flg, e_lat);
        start  = 1'b1;
        opcode = 2'(op);
        op_a   = 14'(a);
        op_b   = 14'(b);
        tick();
        start = 1'b0;
        scramble();
        check("busy_after_start", busy, 1);
        cnt = 1;
        while (done !== 1'b1 && cnt < 40) begin
            start = (mid_start && cnt == 3);
            scramble();
            tick();
            cnt++;
            if (done !== 1'b1) check("busy_in_calc", busy, 1);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (e_lat >= 0) check("latency", cnt, e_lat);
        check("result", Result, e_res);
        check("flag", flag, e_flg);
        check("busy_in_done", busy, 0);
        // start during the DONE cycle must be ignored
        start  = 1'b1;
        opcode = 2'b00;
        op_a   = 14'd1;
        op_b   = 14'd1;
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);
        check("result_hold", Result, e_res);
        check("flag_hold", flag, e_flg);
        tick();
        check("still_idle", busy, 0);
    endtask

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 11);
        if (sel == 0) return $urandom_range(10000, 16383);
        if (sel == 1) return 0;
        if (sel < 6) return $urandom_range(1, 150);
        return $urandom_range(0, MAX);
    endfunction

    initial begin
        int dcount;
        rst    = 1'b1;
        start  = 1'b1;
        opcode = 2'b00;
        op_a   = 14'd1;
        op_b   = 14'd1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", Result, 0);
        check("rst_flag", flag, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        run_op(0, 1234, 4321, 1'b0);
        run_op(1, 5, 7, 1'b0);
        run_op(1, 7, 5, 1'b0);
        run_op(2, 99, 101, 1'b0);
        run_op(2, 100, 100, 1'b0);
        run_op(0, 5000, 4999, 1'b0);
        run_op(0, 5000, 5000, 1'b0);
        run_op(0, 10000, 0, 1'b0);
        run_op(2, 16383, 16383, 1'b0);
        run_op(3, 10, 2, 1'b0);
`ifdef CALC_DIV_EN
        run_op(3, 9999, 7, 1'b1);
        run_op(3, 9999, 0, 1'b0);
        run_op(3, 3, 9999, 1'b0);

        // Reset asserted during the 6th CALC cycle of a divide
        run_op(0, 1234, 4321, 1'b0);
        start  = 1'b1;
        opcode = 2'b11;
        op_a   = 14'd9999;
        op_b   = 14'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`else
        run_op(0, 1234, 4321, 1'b0);
        start  = 1'b1;
        opcode = 2'b00;
        op_a   = 14'd20;
        op_b   = 14'd22;
        tick();
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
`endif
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_result", Result, 0);
        check("abort_flag", flag, 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", dcount, 0);

        for (int i = 0; i < 60; i++) begin
            run_op($urandom_range(0, 3), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
